chimera_cluster_ctrl: RTL and testbench
=======================================

CHIMERA_CLUSTER_CTRL -- requirements
Module: chimera_cluster_ctrl

Interface
REQ-001 Parameter NumClusters, default 5, number of managed clusters; legal range 1..8.
REQ-002 Parameter RstCyclesDefault, default 8, reset value of the RST_CYCLES register.
REQ-003 clk_i  input  1  single clock for all logic.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 reg_valid_i  input  1  register-bus request valid.
REQ-006 reg_write_i  input  1  1 = write, 0 = read.
REQ-007 reg_addr_i  input  12  byte offset within the 4 KiB control region.
REQ-008 reg_wdata_i  input  32  write data.
REQ-009 reg_wstrb_i  input  4  byte enables for writes.
REQ-010 reg_ready_o  output  1  request accepted this cycle.
REQ-011 reg_rdata_o  output  32  read data, valid when reg_valid_i && reg_ready_o.
REQ-012 reg_error_o  output  1  access error, valid when reg_valid_i && reg_ready_o.
REQ-013 cluster_clk_en_o  output  NumClusters  per-cluster clock-gate enable.
REQ-014 cluster_rst_no  output  NumClusters  per-cluster active-low reset.

Function
REQ-015 reg_ready_o SHALL be tied to 1, giving zero-wait accesses; reg_rdata_o SHALL be combinational from the current register state; writes SHALL take effect at the next rising clk_i edge.
REQ-016 The register map SHALL be as follows, decoded on reg_addr_i[11:2], with bits above NumClusters-1 reading 0:
- 0x000 CLK_EN: RW, reset 0.
- 0x004 RST_REQ: write-1-to-trigger, self-clearing; reads return BUSY.
- 0x008 RST_CYCLES: RW [7:0], reset RstCyclesDefault.
- 0x00C STATUS: RO BUSY[NumClusters-1:0].
REQ-017 Writes SHALL honour reg_wstrb_i per byte; a RST_REQ write with wstrb[0]=0 SHALL trigger nothing; writes to STATUS SHALL be ignored.
REQ-018 Each cluster SHALL run an independent sequencer with states IDLE, GATE, RST and SETTLE; BUSY[i] = (state != IDLE).
REQ-019 Transition from IDLE to GATE SHALL occur on an accepted RST_REQ write with wdata[i]=1; requests to a cluster already BUSY SHALL be ignored, with no queueing.
REQ-020 GATE SHALL last exactly 2 cycles and then enter RST.
REQ-021 RST SHALL last N cycles, where N is RST_CYCLES latched on entry to GATE, and a value of 0 is treated as 1; it SHALL then enter SETTLE. An 8-bit down-counter per cluster SHALL implement the count.
REQ-022 SETTLE SHALL last exactly 2 cycles and then return to IDLE.
REQ-023 cluster_clk_en_o[i] SHALL be registered: CLK_EN[i] in IDLE, and 0 in GATE, RST and SETTLE.
REQ-024 cluster_rst_no[i] SHALL be registered: 0 in RST, and 1 in every other state.
REQ-025 A write to CLK_EN while a cluster is BUSY SHALL update the register, and the new value SHALL appear on return to IDLE.
REQ-026 A write to RST_CYCLES during a sequence SHALL NOT affect the running count.
REQ-027 Simultaneous RST_REQ bits SHALL start all addressed idle clusters in the same cycle.
REQ-028 A RST_REQ write and a CLK_EN write cannot coincide because only one access occurs per cycle, so no arbitration is required.

Reset
REQ-029 While rst_ni is low, the outputs and state SHALL be as follows:
- all sequencers in IDLE;
- CLK_EN=0, RST_CYCLES=RstCyclesDefault;
- cluster_clk_en_o=0, cluster_rst_no=0.
REQ-030 On the first clk_i edge after rst_ni rises, cluster_rst_no SHALL go all 1; cluster_clk_en_o SHALL stay 0 until CLK_EN is written.
REQ-031 rst_ni asserted mid-sequence SHALL abort the sequence immediately and asynchronously, returning to the REQ-029 values.

Configuration
REQ-032 Macro CHIMERA_CLUSTER_CTRL_ERR_RESP_EN SHALL control error responses:
- Defined: an access to an unmapped offset, or a write to STATUS, SHALL return reg_error_o=1 and rdata 0.
- Undefined: reg_error_o SHALL be tied 0, unmapped reads SHALL return 0, and such writes SHALL be silently dropped.

Verification
REQ-033 Reset then read all registers -> CLK_EN=0, RST_CYCLES=8, STATUS=0; cluster_rst_no=5'h1F after the first edge; cluster_clk_en_o=0.
REQ-034 Write CLK_EN=0x15, wstrb=0xF -> cluster_clk_en_o=5'b10101 one cycle later.
REQ-035 CLK_EN=0x1F, RST_CYCLES=3, write RST_REQ=0x02 -> for cluster 1:
- clk_en low for 7 cycles;
- rst_n low exactly 3 cycles, starting 2 cycles after clk_en falls;
- STATUS=0x02 throughout, then 0;
- the other clusters are unaffected.
REQ-036 Write RST_REQ=0x02 again 2 cycles into a running sequence, then RST_CYCLES=20 -> the request is ignored and the sequence still ends after 7 cycles total.
REQ-037 RST_CYCLES=0 with RST_REQ=0x11 -> clusters 0 and 4 run in lockstep with a 1-cycle reset pulse, and rst_ni pulsed mid-RST returns all outputs to reset values.
REQ-038 Read offset 0x010 -> with the macro defined: error=1, rdata=0; without the macro: error=0, rdata=0.

Source files
------------

// File: rtl/chimera_cluster_ctrl.sv
// Register-mapped clock-gate and reset sequencer for NumClusters compute clusters.
// Optional macro CHIMERA_CLUSTER_CTRL_ERR_RESP_EN turns on error responses for illegal accesses.
module chimera_cluster_ctrl #(
    parameter int unsigned NumClusters      = 5,
    parameter int unsigned RstCyclesDefault = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   reg_valid_i,
    input  logic                   reg_write_i,
    input  logic [11:0]            reg_addr_i,
    input  logic [31:0]            reg_wdata_i,
    input  logic [3:0]             reg_wstrb_i,
    output logic                   reg_ready_o,
    output logic [31:0]            reg_rdata_o,
    output logic                   reg_error_o,
    output logic [NumClusters-1:0] cluster_clk_en_o,
    output logic [NumClusters-1:0] cluster_rst_no
);

    typedef enum logic [1:0] {
        Idle   = 2'd0,
        Gate   = 2'd1,
        Rst    = 2'd2,
        Settle = 2'd3
    } seqState_e;

    localparam logic [9:0] AddrClkEn     = 10'd0;
    localparam logic [9:0] AddrRstReq    = 10'd1;
    localparam logic [9:0] AddrRstCycles = 10'd2;
    localparam logic [9:0] AddrStatus    = 10'd3;

    logic [9:0]             addrIdx;
    logic                   wrEn;
    logic                   clkEnWr;
    logic                   rstReqWr;
    logic                   rstCyclesWr;
    logic                   isMapped;
    logic                   accErr;
    logic [NumClusters-1:0] clkEn;
    logic [NumClusters-1:0] busy;
    logic [NumClusters-1:0] startReq;
    logic [7:0]             rstCycles;
    logic [7:0]             rstCyclesEff;
    logic                   unusedBits;

    // Per-cluster sequencer state, visible for debug and checker binding.
    logic [NumClusters-1:0][1:0] seqStateDbg;

    assign reg_ready_o = 1'b1;
    assign addrIdx     = reg_addr_i[11:2];
    assign wrEn        = reg_valid_i && reg_write_i;
    assign isMapped    = (addrIdx <= AddrStatus);
    assign clkEnWr     = wrEn && (addrIdx == AddrClkEn) && reg_wstrb_i[0];
    assign rstReqWr    = wrEn && (addrIdx == AddrRstReq) && reg_wstrb_i[0];
    assign rstCyclesWr = wrEn && (addrIdx == AddrRstCycles) && reg_wstrb_i[0];
    assign unusedBits  = ^{reg_addr_i[1:0], reg_wdata_i[31:8], reg_wstrb_i[3:1]};

`ifdef CHIMERA_CLUSTER_CTRL_ERR_RESP_EN
    assign accErr = reg_valid_i && (!isMapped || (reg_write_i && (addrIdx == AddrStatus)));
`else
    assign accErr = 1'b0;
`endif
    assign reg_error_o = accErr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clkEn     <= '0;
            rstCycles <= 8'(RstCyclesDefault);
        end else begin
            if (clkEnWr) begin
                clkEn <= reg_wdata_i[NumClusters-1:0];
            end
            if (rstCyclesWr) begin
                rstCycles <= reg_wdata_i[7:0];
            end
        end
    end

    always_comb begin
        reg_rdata_o = '0;
        if (!accErr && isMapped) begin
            case (addrIdx)
                AddrClkEn:              reg_rdata_o[NumClusters-1:0] = clkEn;
                AddrRstReq, AddrStatus: reg_rdata_o[NumClusters-1:0] = busy;
                AddrRstCycles:          reg_rdata_o[7:0]             = rstCycles;
                default:                reg_rdata_o                  = '0;
            endcase
        end
    end

    // A programmed length of zero still yields a one-cycle reset pulse.
    assign rstCyclesEff = (rstCycles == 8'd0) ? 8'd1 : rstCycles;
    assign startReq     = rstReqWr ? reg_wdata_i[NumClusters-1:0] : '0;

    for (genvar i = 0; i < NumClusters; i++) begin : gSeq
        seqState_e  state;
        seqState_e  stateNext;
        logic [7:0] cnt;
        logic [7:0] cntNext;
        logic       phase;
        logic       phaseNext;
        logic       clkEnQ;
        logic       rstNQ;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state  <= Idle;
                cnt    <= '0;
                phase  <= 1'b0;
                clkEnQ <= 1'b0;
                rstNQ  <= 1'b0;
            end else begin
                state  <= stateNext;
                cnt    <= cntNext;
                phase  <= phaseNext;
                clkEnQ <= (state == Idle) ? clkEn[i] : 1'b0;
                rstNQ  <= (state != Rst);
            end
        end

        // GATE and SETTLE use the phase bit as a fixed two-cycle timer.
        always_comb begin
            stateNext = state;
            cntNext   = cnt;
            phaseNext = phase;
            case (state)
                Idle: begin
                    if (startReq[i]) begin
                        stateNext = Gate;
                        cntNext   = rstCyclesEff;
                        phaseNext = 1'b0;
                    end
                end
                Gate: begin
                    if (phase) begin
                        stateNext = Rst;
                        phaseNext = 1'b0;
                    end else begin
                        phaseNext = 1'b1;
                    end
                end
                Rst: begin
                    if (cnt <= 8'd1) begin
                        stateNext = Settle;
                    end else begin
                        cntNext = cnt - 8'd1;
                    end
                end
                Settle: begin
                    if (phase) begin
                        stateNext = Idle;
                        phaseNext = 1'b0;
                    end else begin
                        phaseNext = 1'b1;
                    end
                end
                default: begin
                    stateNext = Idle;
                    phaseNext = 1'b0;
                end
            endcase
        end

        assign seqStateDbg[i]      = state;
        assign busy[i]             = (seqStateDbg[i] != Idle);
        assign cluster_clk_en_o[i] = clkEnQ;
        assign cluster_rst_no[i]   = rstNQ;
    end

endmodule

// File: tb/tb_chimera_cluster_ctrl.sv
// Self-checking bench for chimera_cluster_ctrl: register access, sequencing timing and async reset abort.
// Expected values come from the programmed timing (GATE 2, RST N, SETTLE 2) and a queue-based scoreboard.
module tb_chimera_cluster_ctrl;

    localparam logic [11:0] AClkEn     = 12'h000;
    localparam logic [11:0] ARstReq    = 12'h004;
    localparam logic [11:0] ARstCycles = 12'h008;
    localparam logic [11:0] AStatus    = 12'h00C;
    localparam logic [11:0] AUnmapped  = 12'h010;

`ifdef CHIMERA_CLUSTER_CTRL_ERR_RESP_EN
    localparam logic ExpUnmappedErr = 1'b1;
`else
    localparam logic ExpUnmappedErr = 1'b0;
`endif

    logic        clk;
    logic        rstN;
    logic        regValid;
    logic        regWrite;
    logic [11:0] regAddr;
    logic [31:0] regWdata;
    logic [3:0]  regWstrb;
    logic        regReady;
    logic [31:0] regRdata;
    logic        regError;
    logic [4:0]  clusterClkEn;
    logic [4:0]  clusterRstN;

    int total = 0;
    int bad   = 0;

    // Scoreboard queues: {busy, clk_en, rst_n} per cycle, and {error, rdata} per read.
    logic [14:0] traceQ[$];
    logic [32:0] readQ[$];

    chimera_cluster_ctrl #(
        .NumClusters(5),
        .RstCyclesDefault(8)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rstN),
        .reg_valid_i     (regValid),
        .reg_write_i     (regWrite),
        .reg_addr_i      (regAddr),
        .reg_wdata_i     (regWdata),
        .reg_wstrb_i     (regWstrb),
        .reg_ready_o     (regReady),
        .reg_rdata_o     (regRdata),
        .reg_error_o     (regError),
        .cluster_clk_en_o(clusterClkEn),
        .cluster_rst_no  (clusterRstN)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h", tag, got, exp);
        end
    endtask

    // Idle bus parks on a side-effect-free STATUS read so busy can be observed.
    task automatic park();
        regValid = 1'b1;
        regWrite = 1'b0;
        regAddr  = AStatus;
        regWdata = '0;
        regWstrb = '0;
    endtask

    task automatic busWrite(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
        regValid = 1'b1;
        regWrite = 1'b1;
        regAddr  = addr;
        regWdata = data;
        regWstrb = strb;
        @(posedge clk);
        #1;
        park();
    endtask

    task automatic busRead(input string tag, input logic [11:0] addr, input logic [31:0] expData,
                           input logic expErr);
        logic [32:0] exp;
        regValid = 1'b1;
        regWrite = 1'b0;
        regAddr  = addr;
        readQ.push_back({expErr, expData});
        #2;
        exp = readQ.pop_front();
        checkVal(tag, {regError, regRdata}, exp);
        park();
    endtask

    // Expected outputs t cycles after the RST_REQ write edge.
    function automatic logic [14:0] expTrace(input int t, input int n, input logic [4:0] mask,
                                             input logic [4:0] enReg);
        int         nEff;
        logic [4:0] busyE;
        logic [4:0] enE;
        logic [4:0] rstE;
        nEff = (n == 0) ? 1 : n;
        for (int i = 0; i < 5; i++) begin
            if (mask[i]) begin
                busyE[i] = (t < 4 + nEff);
                enE[i]   = (t >= 1 && t <= 4 + nEff) ? 1'b0 : enReg[i];
                rstE[i]  = !(t >= 3 && t <= 2 + nEff);
            end else begin
                busyE[i] = 1'b0;
                enE[i]   = enReg[i];
                rstE[i]  = 1'b1;
            end
        end
        return {busyE, enE, rstE};
    endfunction

    task automatic startSeq(input logic [4:0] mask, input int n, input logic [4:0] enReg, input int len);
        for (int t = 0; t < len; t++) begin
            traceQ.push_back(expTrace(t, n, mask, enReg));
        end
        busWrite(ARstReq, {27'd0, mask}, 4'hF);
    endtask

    task automatic drainTrace(input string tag);
        logic [14:0] exp;
        while (traceQ.size() > 0) begin
            @(negedge clk);
            exp = traceQ.pop_front();
            checkVal({tag, "_out"}, {clusterClkEn, clusterRstN}, exp[9:0]);
            if (regValid && !regWrite && regAddr == AStatus) begin
                checkVal({tag, "_busy"}, regRdata, {27'd0, exp[14:10]});
            end
        end
    endtask

    initial begin
        rstN = 1'b0;
        park();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_clken", clusterClkEn, 5'h00);
        checkVal("rst_rstn", clusterRstN, 5'h00);
        checkVal("ready", regReady, 1'b1);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkVal("rstn_before_edge", clusterRstN, 5'h00);
        @(posedge clk);
        #1;
        checkVal("rstn_after_edge", clusterRstN, 5'h1F);
        checkVal("clken_after_edge", clusterClkEn, 5'h00);
        busRead("rd_clken", AClkEn, 32'h0, 1'b0);
        busRead("rd_rstcyc", ARstCycles, 32'h8, 1'b0);
        busRead("rd_status", AStatus, 32'h0, 1'b0);
        busRead("rd_unmapped", AUnmapped, 32'h0, ExpUnmappedErr);

        // Clock enable write and byte strobes
        busWrite(AClkEn, 32'h15, 4'hF);
        checkVal("clken_same_cycle", clusterClkEn, 5'h00);
        @(posedge clk);
        #1;
        checkVal("clken_15", clusterClkEn, 5'h15);
        busWrite(AClkEn, 32'hFF, 4'hE);
        busRead("clken_strb_off", AClkEn, 32'h15, 1'b0);
        busWrite(ARstReq, 32'h1F, 4'hE);
        busRead("rstreq_strb_off", AStatus, 32'h0, 1'b0);
        busWrite(AStatus, 32'h1F, 4'hF);
        busRead("status_write_ignored", AStatus, 32'h0, 1'b0);

        // Single-cluster sequence, N=3
        busWrite(AClkEn, 32'h1F, 4'hF);
        busWrite(ARstCycles, 32'h3, 4'h1);
        busRead("rstcyc_3", ARstCycles, 32'h3, 1'b0);
        startSeq(5'h02, 3, 5'h1F, 10);
        drainTrace("seq1");

        // Re-request while busy and RST_CYCLES change mid-sequence are both ignored
        startSeq(5'h02, 3, 5'h1F, 10);
        fork
            drainTrace("seq2");
            begin
                @(posedge clk);
                #1;
                busWrite(ARstReq, 32'h02, 4'hF);
                busWrite(ARstCycles, 32'd20, 4'hF);
            end
        join
        busRead("rstcyc_20", ARstCycles, 32'd20, 1'b0);

        // Zero length in lockstep, then asynchronous abort mid-RST
        busWrite(ARstCycles, 32'h0, 4'h1);
        startSeq(5'h11, 0, 5'h1F, 3);
        drainTrace("seq3");
        #2;
        rstN = 1'b0;
        #1;
        checkVal("abort_clken", clusterClkEn, 5'h00);
        checkVal("abort_rstn", clusterRstN, 5'h00);
        busRead("abort_status", AStatus, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        checkVal("post_abort_rstn", clusterRstN, 5'h1F);
        checkVal("post_abort_clken", clusterClkEn, 5'h00);
        busRead("post_abort_clkenreg", AClkEn, 32'h0, 1'b0);
        busRead("post_abort_rstcyc", ARstCycles, 32'h8, 1'b0);

        // CLK_EN written while busy shows up on return to IDLE
        busWrite(ARstCycles, 32'h1, 4'h1);
        busWrite(ARstReq, 32'h04, 4'hF);
        busWrite(AClkEn, 32'h04, 4'hF);
        checkVal("busy_clken_t1", clusterClkEn, 5'h00);
        repeat (4) @(posedge clk);
        #1;
        checkVal("busy_clken_t5", clusterClkEn, 5'h00);
        @(posedge clk);
        #1;
        checkVal("busy_clken_t6", clusterClkEn, 5'h04);
        busRead("busy_done_status", AStatus, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
